// File: rtl/db_io_pkg.sv
// -----------------------------------------------------------------------------
// db_io_pkg
// Shared defaults and helpers for the daughterboard I/O bank.
//   DEF_NCH / DEF_SYNC_STAGES / DEF_FILT_LEN : default bank geometry
//   IOBUF_TRISTATE                           : IOBUF T level that releases a pad
//   clog2()                                  : ceiling log2 for counter widths
// -----------------------------------------------------------------------------
package db_io_pkg;

    localparam int DEF_NCH         = 6;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_FILT_LEN    = 4;

    localparam logic IOBUF_TRISTATE = 1'b1;

    // Number of bits needed to index 'value' distinct states.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/db_io_if.sv
// -----------------------------------------------------------------------------
// db_io_if
// Control/status bundle between the I2C masters / sense logic and db_io_bank.
//   out_i, oen_i, od_i   : per-channel drive value, active-low enable, open-drain
//   evt_clr_i, evt_en_i  : write-1-to-clear and interrupt enable for events
//   in_o, rise_o, fall_o : filtered pin level and its edge pulses
//   evt_o, irq_o         : sticky change flags and combined interrupt
//   fault_o              : sticky contention flags (DB_IO_CONTENTION_CHECK_EN)
// master = controlling logic, slave = the I/O bank.
// -----------------------------------------------------------------------------
interface db_io_if
    import db_io_pkg::*;
#(
    parameter int NCH = DEF_NCH
);
    logic [NCH-1:0] out_i;
    logic [NCH-1:0] oen_i;
    logic [NCH-1:0] od_i;
    logic [NCH-1:0] evt_clr_i;
    logic [NCH-1:0] evt_en_i;
    logic [NCH-1:0] in_o;
    logic [NCH-1:0] rise_o;
    logic [NCH-1:0] fall_o;
    logic [NCH-1:0] evt_o;
    logic           irq_o;
`ifdef DB_IO_CONTENTION_CHECK_EN
    logic [NCH-1:0] fault_o;
`endif

    modport master (
        output out_i, oen_i, od_i, evt_clr_i, evt_en_i,
        input  in_o, rise_o, fall_o, evt_o, irq_o
`ifdef DB_IO_CONTENTION_CHECK_EN
        , input fault_o
`endif
    );

    modport slave (
        input  out_i, oen_i, od_i, evt_clr_i, evt_en_i,
        output in_o, rise_o, fall_o, evt_o, irq_o
`ifdef DB_IO_CONTENTION_CHECK_EN
        , output fault_o
`endif
    );

endinterface

// File: rtl/db_io_filter.sv
// -----------------------------------------------------------------------------
// db_io_filter
// One pin channel's input path: synchroniser, glitch filter, edge pulses.
//   clk_i, rst_n_i : clock, async active-low reset
//   pad            : raw pad level (asynchronous)
//   level          : synchronised, filtered level (INIT_LEVEL in reset)
//   rise, fall     : one-cycle pulses the cycle after 'level' changes
// A new level is accepted after FILT_LEN consecutive disagreeing samples;
// FILT_LEN = 0 passes the synchroniser output straight through.
// -----------------------------------------------------------------------------
module db_io_filter
    import db_io_pkg::*;
#(
    parameter int   SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int   FILT_LEN    = DEF_FILT_LEN,
    parameter int   FILT_BITS   = 3,
    parameter logic INIT_LEVEL  = 1'b1
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic pad,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic                   prev_q;
    logic                   rise_q;
    logic                   fall_q;

    // NOTE: every synchroniser flop is preset so the filter sees the pull-up
    // level immediately after reset instead of a stale pre-reset sample.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= {SYNC_STAGES{INIT_LEVEL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pad};
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

    generate
        if (FILT_LEN == 0) begin : g_bypass
            assign level = synced;
        end else begin : g_filter
            logic [FILT_BITS-1:0] cnt_q;
            logic                 level_q;

            // NOTE: non-blocking assignments keep counter and level updates
            // consistent with each other within the same clock edge.
            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    cnt_q   <= '0;
                    level_q <= INIT_LEVEL;
                end else if (synced == level_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == FILT_BITS'(FILT_LEN - 1)) begin
                    level_q <= ~level_q;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end

            assign level = level_q;
        end
    endgenerate

    // prev_q lags level by one cycle, so the pulses land the cycle after the
    // level changes and last exactly one cycle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            prev_q <= INIT_LEVEL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            prev_q <= level;
            rise_q <= level & ~prev_q;
            fall_q <= ~level & prev_q;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: rtl/db_io_bank.sv
// -----------------------------------------------------------------------------
// db_io_bank
// NCH bidirectional daughterboard pins with registered drive, open-drain mode,
// filtered inputs, edge detection, sticky events and a combined interrupt.
//   clk_i, rst_n_i : clock, async active-low reset (pads released at once)
//   pad_io         : daughterboard pins
//   bus            : db_io_if.slave control/status bundle
// Optional: DB_IO_CONTENTION_CHECK_EN adds bus.fault_o, flagging a driven pin
// whose filtered level disagrees with the driven value once it has settled.
// Channels with IMPLEMENT_MASK[n]=0 never drive and report INIT_LEVEL[n].
// -----------------------------------------------------------------------------
module db_io_bank
    import db_io_pkg::*;
#(
    parameter int             NCH            = DEF_NCH,
    parameter logic [NCH-1:0] IMPLEMENT_MASK = {NCH{1'b1}},
    parameter int             SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter int             FILT_LEN       = DEF_FILT_LEN,
    parameter int             FILT_BITS      = (clog2(FILT_LEN + 1) > 0) ? clog2(FILT_LEN + 1) : 1,
    parameter logic [NCH-1:0] INIT_LEVEL     = {NCH{1'b1}}
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    inout  wire [NCH-1:0]   pad_io,
    db_io_if.slave          bus
);

    logic [NCH-1:0] t_d, i_d;
    logic [NCH-1:0] t_q, i_q;
    logic [NCH-1:0] level, rise, fall;
    logic [NCH-1:0] evt_q;
    logic           irq_q;

    // Open-drain releases the pad for a 1 and pulls low for a 0, so the drive
    // value becomes the tristate control and the data input is tied low.
    assign t_d = (bus.od_i & bus.out_i) | (~bus.od_i & bus.oen_i);
    assign i_d = ~bus.od_i & bus.out_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            t_q <= {NCH{IOBUF_TRISTATE}};
            i_q <= '0;
        end else begin
            t_q <= t_d;
            i_q <= i_d;
        end
    end

    generate
        for (genvar n = 0; n < NCH; n++) begin : g_ch
            if (IMPLEMENT_MASK[n]) begin : g_impl
                assign pad_io[n] = (t_q[n] == IOBUF_TRISTATE) ? 1'bz : i_q[n];

                db_io_filter #(
                    .SYNC_STAGES (SYNC_STAGES),
                    .FILT_LEN    (FILT_LEN),
                    .FILT_BITS   (FILT_BITS),
                    .INIT_LEVEL  (INIT_LEVEL[n])
                ) u_filter (
                    .clk_i   (clk_i),
                    .rst_n_i (rst_n_i),
                    .pad     (pad_io[n]),
                    .level   (level[n]),
                    .rise    (rise[n]),
                    .fall    (fall[n])
                );
            end else begin : g_inert
                assign level[n] = INIT_LEVEL[n];
                assign rise[n]  = 1'b0;
                assign fall[n]  = 1'b0;
                wire unused_ch = &{1'b0, pad_io[n], t_q[n], i_q[n]};
            end
        end
    endgenerate

`ifdef DB_IO_CONTENTION_CHECK_EN
    // The comparison is only trusted once a driven value has been stable long
    // enough to propagate through the synchroniser and filter.
    localparam int HOLD      = FILT_LEN + SYNC_STAGES + 1;
    localparam int HOLD_BITS = clog2(HOLD + 1);

    logic [HOLD_BITS-1:0] hold_q [NCH];
    logic [NCH-1:0]       mismatch;
    logic [NCH-1:0]       fault_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int n = 0; n < NCH; n++) hold_q[n] <= '0;
        end else begin
            for (int n = 0; n < NCH; n++) begin
                if ({t_d[n], i_d[n]} != {t_q[n], i_q[n]}) begin
                    hold_q[n] <= '0;
                end else if (hold_q[n] != HOLD_BITS'(HOLD)) begin
                    hold_q[n] <= hold_q[n] + 1'b1;
                end
            end
        end
    end

    // NOTE: default assigned first so no channel path can infer a latch.
    always_comb begin
        mismatch = '0;
        for (int n = 0; n < NCH; n++) begin
            mismatch[n] = IMPLEMENT_MASK[n] && (t_q[n] != IOBUF_TRISTATE) &&
                          (level[n] != i_q[n]) && (hold_q[n] == HOLD_BITS'(HOLD));
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            fault_q <= '0;
        end else begin
            fault_q <= (fault_q & ~bus.evt_clr_i) | mismatch;
        end
    end

    assign bus.fault_o = fault_q;
`endif

    // Set wins over a simultaneous clear so an edge is never lost.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            evt_q <= '0;
            irq_q <= 1'b0;
        end else begin
            evt_q <= (evt_q & ~bus.evt_clr_i) | rise | fall;
`ifdef DB_IO_CONTENTION_CHECK_EN
            irq_q <= |((evt_q | fault_q) & bus.evt_en_i);
`else
            irq_q <= |(evt_q & bus.evt_en_i);
`endif
        end
    end

    assign bus.in_o   = level;
    assign bus.rise_o = rise;
    assign bus.fall_o = fall;
    assign bus.evt_o  = evt_q;
    assign bus.irq_o  = irq_q;

endmodule
